// File: rtl/memory_pkg.sv
// Shared types and default sizes for the memory_init block and its fill sequencer.
package memory_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    FILL = 1'b0,
    ADDR = 1'b1
  } init_mode_e;

endpackage

// File: rtl/memory_init_seq.sv
// Fill sequencer: walks every word address once and supplies the word to write.
// The fill settings are captured when the fill is accepted, so the inputs may
// change while the fill runs.
module memory_init_seq
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  input  logic                  init_mode,
  input  logic [DATA_WIDTH-1:0] init_value,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  init_done
);

  // Final address of the sweep; a non-power-of-two depth stops here exactly.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
  init_mode_e            mode_q,  mode_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;

  // State, counter and captured fill settings; reset aborts any fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= FILL;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      value_q <= value_d;
    end
  end

  // Next-state logic: one word per INIT cycle, a single DONE cycle, then back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    value_d = value_q;
    fill_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = INIT;
          cnt_d   = '0;
          mode_d  = init_mode_e'(init_mode);
          value_d = init_value;
        end
      end
      INIT: begin
        fill_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ADDR mode writes the address itself, zero-extended or truncated to a word.
  assign fill_addr = cnt_q;
  assign fill_data = (mode_q == ADDR) ? DATA_WIDTH'(cnt_q) : value_q;
  assign busy      = (state_q != IDLE);
  assign init_done = (state_q == DONE);

endmodule

// File: rtl/memory_init.sv
// Single-port word memory with byte enables, registered read data and a
// hardware fill engine. User accesses are locked out while a fill runs.
module memory_init
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  input  logic                    init_start,
  input  logic                    init_mode,
  input  logic [DATA_WIDTH-1:0]   init_value,
  output logic                    busy,
  output logic                    init_done,
  output logic                    err
);

  localparam int NBYTES = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("memory_init: DATA_WIDTH must be a multiple of 8");
  end
  if (longint'(MEM_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
    $error("memory_init: MEM_DEPTH exceeds 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  in_range;
  logic                  user_wr;

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_q,      err_d;

  memory_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .init_mode  (init_mode),
    .init_value (init_value),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .busy       (busy),
    .init_done  (init_done)
  );

  // Extra top bit keeps the compare meaningful when MEM_DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
  assign user_wr  = write && !busy && in_range;

  // Array update: the fill owns the array while busy, otherwise byte-masked user writes.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= fill_data;
    end else if (user_wr) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= data_in[8*k +: 8];
      end
    end
  end

  // Read/err decode; reading the array before the write lands gives read-first behaviour.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    if (busy) begin
      err_d = read || write;
    end else begin
      err_d = (read || write) && !in_range;
      if (read) begin
        rd_valid_d = 1'b1;
        data_out_d = in_range ? mem[addr] : '0;
      end
    end
  end

  // Registered read data and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_memory_init.sv
// Bench for memory_init: a default-size instance checked against an array
// model, plus a narrow non-power-of-two instance for range and depth handling.
module tb_memory_init;

  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int NB      = DW / 8;
  localparam int DEPTH   = 512;
  localparam int S_DW    = 16;
  localparam int S_NB    = S_DW / 8;
  localparam int S_DEPTH = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          read, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [NB-1:0] be;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          init_start, init_mode;
  logic [DW-1:0] init_value;
  logic          busy, init_done, err;

  logic            s_read, s_write;
  logic [AW-1:0]   s_addr;
  logic [S_DW-1:0] s_data_in;
  logic [S_NB-1:0] s_be;
  logic [S_DW-1:0] s_data_out;
  logic            s_rd_valid;
  logic            s_init_start, s_init_mode;
  logic [S_DW-1:0] s_init_value;
  logic            s_busy, s_init_done, s_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];

  memory_init dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .be(be), .data_out(data_out), .rd_valid(rd_valid),
    .init_start(init_start), .init_mode(init_mode), .init_value(init_value),
    .busy(busy), .init_done(init_done), .err(err)
  );

  memory_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(S_DW), .MEM_DEPTH(S_DEPTH)) dut_s (
    .clk(clk), .rst_n(rst_n), .read(s_read), .write(s_write), .addr(s_addr),
    .data_in(s_data_in), .be(s_be), .data_out(s_data_out), .rd_valid(s_rd_valid),
    .init_start(s_init_start), .init_mode(s_init_mode), .init_value(s_init_value),
    .busy(s_busy), .init_done(s_init_done), .err(s_err)
  );

  // Byte-enable semantics as a bit mask: enabled bytes come from the new word.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] b);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) m |= {{(DW-8){1'b0}}, {8{b[k]}}} << (8 * k);
    return (old_w & ~m) | (new_w & m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a, output logic [DW-1:0] d, output logic v, output logic e);
    read = 1'b1; addr = AW'(a);
    tick();
    d = data_out; v = rd_valid; e = err;
    read = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] b,
                          output logic e);
    write = 1'b1; addr = AW'(a); data_in = d; be = b;
    tick();
    e = err;
    write = 1'b0;
    model[a] = merge(model[a], d, b);
  endtask

  task automatic wait_fill(output int nbusy, output int ndone);
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      nbusy++;
      if (init_done) ndone++;
      tick();
    end
  endtask

  task automatic start_fill(input logic mode, input logic [DW-1:0] value);
    init_start = 1'b1; init_mode = mode; init_value = value;
    tick();
    init_start = 1'b0; init_mode = 1'b0; init_value = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read = 0; write = 0; addr = '0; data_in = '0; be = '0;
    init_start = 0; init_mode = 0; init_value = '0;
    s_read = 0; s_write = 0; s_addr = '0; s_data_in = '0; s_be = '0;
    s_init_start = 0; s_init_mode = 0; s_init_value = '0;
    tick(); tick();
    checks++;
    if ({data_out, rd_valid, busy, init_done, err} !== {{DW{1'b0}}, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs: got data_out=%h rd_valid=%b busy=%b init_done=%b err=%b required all zero",
               data_out, rd_valid, busy, init_done, err);
    end
    checks++;
    if ({s_data_out, s_rd_valid, s_busy, s_init_done, s_err} !== {{S_DW{1'b0}}, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs_small: got data_out=%h busy=%b required all zero", s_data_out, s_busy);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_zero();
    int nb, nd;
    int bad;
    logic [DW-1:0] d; logic v, e;
    start_fill(1'b0, '0);
    wait_fill(nb, nd);
    checks++;
    if (nb != DEPTH + 1) begin errors++; $display("FAIL fill_zero_busy_cycles: got %0d required %0d", nb, DEPTH + 1); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL fill_zero_done_pulses: got %0d required 1", nd); end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i, d, v, e);
      checks++;
      if (d !== model[i] || v !== 1'b1) begin
        errors++;
        if (bad++ < 4) $display("FAIL fill_zero_read[%0d]: got %h valid=%b required %h valid=1", i, d, v, model[i]);
      end
    end
  endtask

  task automatic test_fill_addr();
    int nb, nd;
    int bad;
    logic [DW-1:0] d; logic v, e;
    start_fill(1'b1, 32'hDEAD_BEEF);
    wait_fill(nb, nd);
    checks++;
    if (nb != DEPTH + 1 || nd != 1) begin
      errors++; $display("FAIL fill_addr_timing: got busy=%0d done=%0d required %0d/1", nb, nd, DEPTH + 1);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = DW'(i);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i, d, v, e);
      checks++;
      if (d !== model[i] || v !== 1'b1 || e !== 1'b0) begin
        errors++;
        if (bad++ < 4) $display("FAIL fill_addr_read[%0d]: got %h required %h", i, d, model[i]);
      end
    end
    do_read(300, d, v, e);
    checks++;
    if (d !== 32'd300) begin errors++; $display("FAIL fill_addr_300: got %h required %h", d, 32'd300); end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] d; logic v, e;
    do_write(5, 32'hAABB_CCDD, 4'b1111, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL be_write_err: got %b required 0", e); end
    do_write(5, 32'h1122_3344, 4'b0101, e);
    do_read(5, d, v, e);
    checks++;
    if (d !== 32'hAA22_CC44 || d !== model[5]) begin
      errors++; $display("FAIL be_merge: got %h required %h", d, 32'hAA22_CC44);
    end
  endtask

  task automatic test_rw_same();
    logic [DW-1:0] d; logic v, e;
    do_write(7, 32'h1, 4'hF, e);
    read = 1'b1; write = 1'b1; addr = AW'(7); data_in = 32'h2; be = 4'hF;
    tick();
    read = 1'b0; write = 1'b0;
    model[7] = 32'h2;
    checks++;
    if (data_out !== 32'h1 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL rw_same_read_first: got %h valid=%b required 00000001 valid=1", data_out, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || data_out !== 32'h1) begin
      errors++; $display("FAIL idle_hold: got %h valid=%b required 00000001 valid=0", data_out, rd_valid);
    end
    do_read(7, d, v, e);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL rw_same_new_data: got %h required 00000002", d); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d; logic v, e;
    int a;
    int bad = 0;
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, DW'($urandom), NB'($urandom), e);
        checks++;
        if (e !== 1'b0) begin errors++; if (bad++ < 4) $display("FAIL random_write_err[%0d]: got %b required 0", a, e); end
      end else begin
        do_read(a, d, v, e);
        checks++;
        if (d !== model[a] || v !== 1'b1 || e !== 1'b0) begin
          errors++;
          if (bad++ < 4) $display("FAIL random_read[%0d]: got %h v=%b e=%b required %h v=1 e=0", a, d, v, e, model[a]);
        end
      end
    end
  endtask

  task automatic test_busy_access();
    int nb, nd;
    logic [DW-1:0] fv, held, d;
    logic v, e;
    fv = DW'($urandom) | 32'h0000_0100;
    held = data_out;
    start_fill(1'b0, fv);
    read = 1'b1; addr = AW'(3);
    tick();
    read = 1'b0;
    checks++;
    if (err !== 1'b1 || rd_valid !== 1'b0 || data_out !== held) begin
      errors++; $display("FAIL busy_read: got err=%b valid=%b data=%h required err=1 valid=0 data=%h",
                         err, rd_valid, data_out, held);
    end
    write = 1'b1; addr = AW'(3); data_in = 32'hFFFF_FFFF; be = 4'hF;
    tick();
    write = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b required 1", err); end
    init_start = 1'b1; init_mode = 1'b1;
    tick();
    init_start = 1'b0; init_mode = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL busy_init_start_err: got %b required 0", err); end
    wait_fill(nb, nd);
    checks++;
    if (nb + 3 != DEPTH + 1 || nd != 1) begin
      errors++; $display("FAIL busy_fill_timing: got busy=%0d done=%0d required %0d/1", nb + 3, nd, DEPTH + 1);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = fv;
    do_read(3, d, v, e);
    checks++;
    if (d !== fv) begin errors++; $display("FAIL busy_addr3_value: got %h required %h", d, fv); end
  endtask

  task automatic test_init_with_access();
    int nb, nd;
    logic [DW-1:0] old, d;
    logic v, e;
    old = model[10];
    read = 1'b1; write = 1'b1; addr = AW'(10); data_in = ~old; be = 4'hF;
    init_start = 1'b1; init_mode = 1'b1;
    tick();
    read = 1'b0; write = 1'b0; init_start = 1'b0; init_mode = 1'b0;
    checks++;
    if (data_out !== old || rd_valid !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL init_with_access: got data=%h v=%b err=%b busy=%b required %h 1 0 1",
                         data_out, rd_valid, err, busy, old);
    end
    wait_fill(nb, nd);
    checks++;
    if (nb != DEPTH + 1 || nd != 1) begin
      errors++; $display("FAIL init_with_access_timing: got busy=%0d done=%0d required %0d/1", nb, nd, DEPTH + 1);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = DW'(i);
    do_read(10, d, v, e);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL init_with_access_after: got %h required %h", d, 32'd10); end
  endtask

  task automatic test_reset_mid_fill();
    int nb, nd, bad_done;
    logic [DW-1:0] fv, d;
    logic v, e;
    int a;
    start_fill(1'b1, '0);
    for (int i = 0; i < 99; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b0 || data_out !== '0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_fill_async: got busy=%b done=%b data=%h required 0 0 0",
                         busy, init_done, data_out);
    end
    bad_done = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (init_done !== 1'b0) bad_done++; end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (init_done !== 1'b0 || busy !== 1'b0) bad_done++; end
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL reset_mid_fill_no_done: got %0d bad cycles required 0", bad_done); end
    fv = DW'($urandom);
    start_fill(1'b0, fv);
    wait_fill(nb, nd);
    checks++;
    if (nb != DEPTH + 1 || nd != 1) begin
      errors++; $display("FAIL refill_timing: got busy=%0d done=%0d required %0d/1", nb, nd, DEPTH + 1);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = fv;
    for (int n = 0; n < 20; n++) begin
      a = (n == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
      do_read(a, d, v, e);
      checks++;
      if (d !== model[a]) begin errors++; $display("FAIL refill_read[%0d]: got %h required %h", a, d, model[a]); end
    end
  endtask

  task automatic test_small_depth();
    int nb, nd, bad;
    logic [S_DW-1:0] exp299;
    s_init_start = 1'b1; s_init_mode = 1'b1; s_init_value = 16'h5555;
    tick();
    s_init_start = 1'b0; s_init_mode = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!s_busy) break;
      nb++;
      if (s_init_done) nd++;
      tick();
    end
    checks++;
    if (nb != S_DEPTH + 1 || nd != 1) begin
      errors++; $display("FAIL small_fill_timing: got busy=%0d done=%0d required %0d/1", nb, nd, S_DEPTH + 1);
    end
    bad = 0;
    for (int i = 0; i < S_DEPTH; i++) begin
      s_read = 1'b1; s_addr = AW'(i);
      tick();
      s_read = 1'b0;
      checks++;
      if (s_data_out !== S_DW'(i) || s_rd_valid !== 1'b1 || s_err !== 1'b0) begin
        errors++;
        if (bad++ < 4) $display("FAIL small_read[%0d]: got %h required %h", i, s_data_out, S_DW'(i));
      end
    end
    for (int n = 0; n < 2; n++) begin
      s_read = 1'b1; s_addr = (n == 0) ? AW'(S_DEPTH) : AW'(511);
      tick();
      s_read = 1'b0;
      checks++;
      if (s_data_out !== '0 || s_rd_valid !== 1'b1 || s_err !== 1'b1) begin
        errors++; $display("FAIL small_oob_read[%0d]: got data=%h v=%b err=%b required 0 1 1",
                           s_addr, s_data_out, s_rd_valid, s_err);
      end
    end
    tick();
    checks++;
    if (s_err !== 1'b0) begin errors++; $display("FAIL small_err_pulse: got %b required 0", s_err); end
    s_write = 1'b1; s_addr = AW'(400); s_data_in = 16'h1234; s_be = 2'b11;
    tick();
    s_write = 1'b0;
    checks++;
    if (s_err !== 1'b1) begin errors++; $display("FAIL small_oob_write_err: got %b required 1", s_err); end
    exp299 = (S_DW'(299) & 16'hFF00) | 16'h00CD;
    s_write = 1'b1; s_addr = AW'(299); s_data_in = 16'hABCD; s_be = 2'b01;
    tick();
    s_write = 1'b0;
    s_read = 1'b1; s_addr = AW'(299);
    tick();
    s_read = 1'b0;
    checks++;
    if (s_data_out !== exp299) begin errors++; $display("FAIL small_be_write: got %h required %h", s_data_out, exp299); end
    s_read = 1'b1; s_addr = AW'(144);
    tick();
    s_read = 1'b0;
    checks++;
    if (s_data_out !== S_DW'(144)) begin errors++; $display("FAIL small_no_alias: got %h required %h", s_data_out, S_DW'(144)); end
  endtask

  initial begin
    test_reset();
    test_fill_zero();
    test_fill_addr();
    test_byte_enable();
    test_rw_same();
    test_random();
    test_busy_access();
    test_init_with_access();
    test_reset_mid_fill();
    test_small_depth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
